// File: rtl/fpu_mmio_sequencer.sv
// fpu_mmio_sequencer: bus master that streams test vectors into the memory-mapped
// FPU, reads each result back, checks it against the expected value and counts
// pass/fail. Optional build macro FPU_SEQ_STATUS_POLL_EN replaces the fixed
// post-command delay with a STATUS poll that has a timeout.
module fpu_mmio_sequencer #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        ADDR_W    = 13,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 13'h0600,
  parameter int unsigned        N_VEC     = 4,
  parameter int unsigned        WAIT_CYC  = 2,
  parameter int unsigned        CNT_W     = 16,
  parameter int unsigned        TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [DATA_W-1:0] vec_a,
  input  logic [DATA_W-1:0] vec_b,
  input  logic [DATA_W-1:0] vec_cmd,
  input  logic [DATA_W-1:0] vec_exp,
  output logic [ADDR_W-1:0] DataAdr,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] ReadData,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [DATA_W-1:0] last_result,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              timeout_flag
);

  localparam int unsigned DLY_MAX = (WAIT_CYC > TIMEOUT) ? WAIT_CYC : TIMEOUT;
  localparam int unsigned DW      = $clog2(DLY_MAX + 1);
  localparam int unsigned IW      = $clog2(N_VEC + 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(N_VEC - 1);
  localparam logic [ADDR_W-1:0] ADR_A    = BASE_ADDR;
  localparam logic [ADDR_W-1:0] ADR_B    = BASE_ADDR + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADR_CMD  = BASE_ADDR + ADDR_W'(8);
  localparam logic [ADDR_W-1:0] ADR_RES  = BASE_ADDR + ADDR_W'(12);
`ifdef FPU_SEQ_STATUS_POLL_EN
  localparam logic [ADDR_W-1:0] ADR_STAT = BASE_ADDR + ADDR_W'(16);
  localparam logic [DW-1:0]     DLY_LAST = DW'(TIMEOUT - 1);
`else
  localparam logic [DW-1:0]     DLY_LAST = DW'(WAIT_CYC - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR_A, S_WR_B, S_WR_CMD,
`ifdef FPU_SEQ_STATUS_POLL_EN
    S_POLL,
`else
    S_WAIT,
`endif
    S_RD, S_CHECK, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] b_q, b_d, cmd_q, cmd_d, exp_q, exp_d;
  logic [DATA_W-1:0] last_q, last_d, wd_q, wd_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
  logic              flag_q, flag_d;
  logic              mis;

  // State and datapath registers; reset clears every visible output at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      idx_q   <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      exp_q   <= '0;
      last_q  <= '0;
      wd_q    <= '0;
      adr_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
      exp_q   <= exp_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      adr_q   <= adr_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state, counters and bus address/data for the state being entered.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    b_d     = b_q;
    cmd_d   = cmd_q;
    exp_d   = exp_q;
    last_d  = last_q;
    wd_d    = wd_q;
    adr_d   = adr_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    flag_d  = flag_q;
    mis     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        pass_d  = '0;
        fail_d  = '0;
        idx_d   = '0;
        flag_d  = 1'b0;
        state_d = S_FETCH;
      end
      S_FETCH: if (vec_valid) begin
        b_d     = vec_b;
        cmd_d   = vec_cmd;
        exp_d   = vec_exp;
        state_d = S_WR_A;
      end
      S_WR_A:   state_d = S_WR_B;
      S_WR_B:   state_d = S_WR_CMD;
      S_WR_CMD: begin
        dly_d = '0;
`ifdef FPU_SEQ_STATUS_POLL_EN
        state_d = S_POLL;
`else
        state_d = S_WAIT;
`endif
      end
`ifdef FPU_SEQ_STATUS_POLL_EN
      S_POLL: begin
        if (ReadData[0]) begin
          state_d = S_RD;
        end else if (dly_q == DLY_LAST) begin
          // Timed-out vector is scored as a failure and skips the result read.
          mis     = 1'b1;
          flag_d  = 1'b1;
          fail_d  = (fail_q == '1) ? fail_q : fail_q + 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == IDX_LAST) ? S_DONE : S_FETCH;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
`else
      S_WAIT: begin
        if (dly_q == DLY_LAST) state_d = S_RD;
        else                   dly_d   = dly_q + 1'b1;
      end
`endif
      S_RD: begin
        last_d  = ReadData;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (last_q == exp_q) begin
          pass_d = (pass_q == '1) ? pass_q : pass_q + 1'b1;
        end else begin
          mis    = 1'b1;
          fail_d = (fail_q == '1) ? fail_q : fail_q + 1'b1;
        end
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == IDX_LAST) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address/data are registered on entry so they are stable for the whole
    // state and simply hold through FETCH/CHECK/DONE/IDLE.
    case (state_d)
      S_WR_A: begin
        adr_d = ADR_A;
        wd_d  = vec_a;
      end
      S_WR_B: begin
        adr_d = ADR_B;
        wd_d  = b_q;
      end
      S_WR_CMD: begin
        adr_d = ADR_CMD;
        wd_d  = cmd_q;
      end
`ifdef FPU_SEQ_STATUS_POLL_EN
      S_POLL:  adr_d = ADR_STAT;
`else
      S_WAIT:  adr_d = ADR_RES;
`endif
      S_RD:    adr_d = ADR_RES;
      default: adr_d = adr_q;
    endcase
  end

  assign vec_ready   = (state_q == S_FETCH);
  assign MemWrite    = (state_q == S_WR_A) || (state_q == S_WR_B) || (state_q == S_WR_CMD);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign mismatch    = mis;
  assign DataAdr     = adr_q;
  assign WriteData   = wd_q;
  assign last_result = last_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
`ifdef FPU_SEQ_STATUS_POLL_EN
  assign timeout_flag = flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_mmio_sequencer.sv
// tb_fpu_mmio_sequencer: directed bench for fpu_mmio_sequencer with a small
// FPU bus model (result = A + B, plus 1 when CMD == 2 to force a mismatch).
module tb_fpu_mmio_sequencer;

  localparam int unsigned NV = 5;

  logic        clk = 1'b0;
  logic        reset, start, vec_valid, vec_ready;
  logic [31:0] vec_a, vec_b, vec_cmd, vec_exp;
  logic [12:0] DataAdr;
  logic [31:0] WriteData, ReadData, last_result;
  logic        MemWrite, busy, done, mismatch, timeout_flag;
  logic [1:0]  pass_cnt, fail_cnt;

  logic [31:0] ra = '0, rb = '0, rc = '0;
  int total = 0, bad = 0, n_mis = 0, n_done = 0;
  int ep, ef;

  logic [31:0] ta [NV] = '{32'd10, 32'd5, 32'd100, 32'hFFFF_FFFF, 32'd3};
  logic [31:0] tb [NV] = '{32'd20, 32'd7, 32'd1,   32'd1,         32'd4};
  logic [31:0] tc [NV] = '{32'd1,  32'd2, 32'd1,   32'd1,         32'd1};
  logic [31:0] te [NV] = '{32'd30, 32'd12, 32'd101, 32'd0,        32'd7};
  logic [31:0] tr [NV] = '{32'd30, 32'd13, 32'd101, 32'd0,        32'd7};

  fpu_mmio_sequencer #(
    .DATA_W(32), .ADDR_W(13), .BASE_ADDR(13'h0600), .N_VEC(NV),
    .WAIT_CYC(2), .CNT_W(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .vec_cmd(vec_cmd), .vec_exp(vec_exp),
    .DataAdr(DataAdr), .WriteData(WriteData), .MemWrite(MemWrite), .ReadData(ReadData),
    .busy(busy), .done(done), .mismatch(mismatch), .last_result(last_result),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  // FPU register model
  always @(posedge clk) begin
    if (MemWrite) begin
      case (DataAdr)
        13'h600: ra <= WriteData;
        13'h604: rb <= WriteData;
        13'h608: rc <= WriteData;
        default: ;
      endcase
    end
    if (mismatch) n_mis  <= n_mis + 1;
    if (done)     n_done <= n_done + 1;
  end

  assign ReadData = (DataAdr == 13'h60C) ? (ra + rb + ((rc == 32'd2) ? 32'd1 : 32'd0)) : 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered with the DUT in FETCH; leaves after the cycle following CHECK.
  task automatic run_vec(input int i, input bit stall);
    chk($sformatf("v%0d ready", i), vec_ready, 1);
    if (stall) begin
      vec_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
        start = (k == 2);
        step();
        chk($sformatf("v%0d stall ready", i), vec_ready, 1);
        chk($sformatf("v%0d stall mw", i), MemWrite, 0);
        chk($sformatf("v%0d stall adr", i), DataAdr, 13'h60C);
      end
      start = 1'b0;
    end
    vec_a = ta[i]; vec_b = tb[i]; vec_cmd = tc[i]; vec_exp = te[i];
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
    chk($sformatf("v%0d wrA", i), {MemWrite, vec_ready, DataAdr, WriteData}, {2'b10, 13'h600, ta[i]});
    step();
    chk($sformatf("v%0d wrB", i), {MemWrite, DataAdr, WriteData}, {1'b1, 13'h604, tb[i]});
    step();
    chk($sformatf("v%0d wrC", i), {MemWrite, DataAdr, WriteData}, {1'b1, 13'h608, tc[i]});
    step();
    chk($sformatf("v%0d wait1", i), {MemWrite, DataAdr, WriteData}, {1'b0, 13'h60C, tc[i]});
    step();
    chk($sformatf("v%0d wait2", i), {MemWrite, DataAdr}, {1'b0, 13'h60C});
    step();
    chk($sformatf("v%0d rd", i), {MemWrite, DataAdr, mismatch}, {1'b0, 13'h60C, 1'b0});
    step();
    chk($sformatf("v%0d chk last", i), last_result, tr[i]);
    chk($sformatf("v%0d chk mis", i), {mismatch, busy}, {(tr[i] != te[i]), 1'b1});
    if (tr[i] == te[i]) ep = (ep < 3) ? ep + 1 : 3;
    else                ef = (ef < 3) ? ef + 1 : 3;
    step();
    chk($sformatf("v%0d pass", i), pass_cnt, ep);
    chk($sformatf("v%0d fail", i), fail_cnt, ef);
  endtask

  task automatic run_all(input int stall_idx, input int mis_total, input int done_total);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run busy", busy, 1);
    ep = 0;
    ef = 0;
    for (int i = 0; i < NV; i++) begin
      run_vec(i, i == stall_idx);
      if (i < NV - 1) chk($sformatf("v%0d next fetch", i), vec_ready, 1);
    end
    chk("done pulse", {done, busy, vec_ready}, 3'b110);
    step();
    chk("idle", {done, busy}, 2'b00);
    chk("final pass", pass_cnt, 3);
    chk("final fail", fail_cnt, 1);
    chk("final last", last_result, 7);
    chk("mis count", n_mis, mis_total);
    chk("done count", n_done, done_total);
    chk("timeout flag", timeout_flag, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vec_valid = 1'b0;
    vec_a = '0; vec_b = '0; vec_cmd = '0; vec_exp = '0;
    step();
    step();
    chk("rst bus", {DataAdr, WriteData, MemWrite}, 0);
    chk("rst flags", {busy, done, mismatch, vec_ready, timeout_flag}, 0);
    chk("rst cnt", {pass_cnt, fail_cnt, last_result}, 0);
    reset = 1'b0;
    step();
    step();
    chk("idle no start", {busy, vec_ready}, 0);

    run_all(2, 1, 1);
    step();
    chk("hold pass", pass_cnt, 3);

    // reset during WR_B
    start = 1'b1;
    step();
    start = 1'b0;
    vec_a = ta[0]; vec_b = tb[0]; vec_cmd = tc[0]; vec_exp = te[0];
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
    step();
    chk("pre-rst wrB", {MemWrite, DataAdr}, {1'b1, 13'h604});
    #1 reset = 1'b1;
    #1;
    chk("async rst mw/busy", {MemWrite, busy, vec_ready}, 0);
    chk("async rst bus", {DataAdr, WriteData}, 0);
    chk("async rst cnt", {pass_cnt, fail_cnt, last_result}, 0);
    step();
    reset = 1'b0;
    step();
    chk("post-rst idle", busy, 0);

    run_all(-1, 2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
